muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative 32-bit multiply/divide unit executing MULT, MULTU, DIV and DIVU. It sits directly upstream of the HI/LO register pair.
- On completion it presents a 64-bit result split into hi_out and lo_out, and pulses ready for one cycle; this drives the HI/LO write of both halves.
- Radix-2 datapath: one bit per clock, 32 iterations, shared between multiply (shift-add) and divide (restoring).

Parameters:
- WIDTH, 32, operand width; hi_out/lo_out are WIDTH each. Iteration count equals WIDTH.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-low reset.
- ena, input, 1, clock enable; when 0, all registers hold.
- start, input, 1, request new operation; sampled only in IDLE with ena=1.
- op, input, 2, operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a, input, WIDTH, multiplicand or dividend (rs).
- b, input, WIDTH, multiplier or divisor (rt).
- busy, output, 1, operation in progress.
- ready, output, 1, single-cycle completion pulse.
- hi_out, output, WIDTH, product upper half, or remainder.
- lo_out, output, WIDTH, product lower half, or quotient.
- div_zero, output, 1, last completed operation was DIV/DIVU with b=0.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state goes to IDLE.
  - busy=0, ready=0, div_zero=0, hi_out=0, lo_out=0.
  - iteration counter and datapath registers cleared.
  - An operation in flight is abandoned; no ready pulse is produced for it.
- States: IDLE, CALC, FIX.
- IDLE:
  - On an edge with ena=1 and start=1, latch op, the sign of a, the sign of b, |a| and |b|.
  - Magnitudes are taken only for MULT/DIV; for MULTU/DIVU raw values are used.
  - Clear counter to 0, then go to CALC.
- CALC: one iteration per enabled edge.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper half of a 2*WIDTH accumulator, then shift right 1.
  - Divide: shift {rem,quo} left 1, trial-subtract the divisor from rem. If the result is non-negative, keep it and set quo LSB=1; otherwise restore and set quo LSB=0.
  - After iteration WIDTH-1 (counter = WIDTH-1), go to FIX.
- FIX, on one edge:
  - Apply sign correction for signed ops.
  - Register hi_out/lo_out, set ready=1 and update div_zero, then go to IDLE.
- Sign rules:
  - MULT: negate the 64-bit product if sign(a) != sign(b).
  - DIV: negate the quotient if sign(a) != sign(b); the remainder takes the sign of a (truncation toward zero).
- Divide by zero (no trap):
  - Raw quotient is all ones and raw remainder is |a|; sign rules are then applied. DIVU x/0 gives lo=0xFFFFFFFF, hi=x; DIV x/0 gives hi=x, with lo=0x00000001 if x<0 and lo=0xFFFFFFFF otherwise.
  - div_zero=1 on that completion.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No flag.
- Latency with ena held 1:
  - Start accepted at edge E0; ready is high in the cycle following edge E0+33, for exactly one cycle.
  - Each cycle with ena=0 adds one cycle of latency.
- busy: 1 from the cycle after the start edge through the FIX cycle; 0 while ready=1.
- Handshake rules:
  - start during CALC/FIX is ignored; no queuing.
  - start in the same cycle as ready=1 (state is IDLE) is accepted.
  - start with ena=0 is ignored.
- Result holding:
  - hi_out, lo_out and div_zero hold their values until the next FIX edge.
  - a, b and op may change freely after the start edge.
- ready is cleared on the next enabled edge after it is set. With ena=0 it stays high until an enabled edge; the consumer gates its write with ena.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. ready pulse exactly 33 edges after the start edge, 1 cycle wide; busy=1 for 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100/7 -> lo=14, hi=2, div_zero=0. DIV 0xFFFFFFF9 (-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_zero=1. DIV 0xFFFFFFF9/0 -> lo=0x00000001, hi=0xFFFFFFF9. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Second start pulsed at iteration 5 of a MULTU -> ignored; first result correct. Back-to-back: start asserted during the ready cycle is accepted, giving a second ready 34 cycles after the first.
- rst low for 1 cycle at iteration 10 of a DIV -> busy=0, outputs 0, no ready. A following DIVU 9/4 completes with lo=2, hi=1. ena=0 for 5 cycles mid-CALC -> ready 38 edges after start with an unchanged result.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit (MULT, MULTU, DIV, DIVU) feeding the HI/LO pair.
// One bit per enabled clock: shift-add multiply, restoring divide, then a single sign-fix cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             ready,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t               state;
   logic [CW-1:0]        count;
   logic                 is_div;
   logic                 sign_a;
   logic                 sign_b;
   logic                 zero_div;
   logic [WIDTH-1:0]     operand;   // multiplicand (multiply) or divisor (divide)
   logic [2*WIDTH-1:0]   acc;       // {upper, multiplier} or {remainder, quotient}

   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       rem_shift;
   logic [WIDTH:0]       trial;
   logic                 trial_neg;
   logic [2*WIDTH-1:0]   acc_next;
   logic [2*WIDTH-1:0]   prod_neg;
   logic [WIDTH-1:0]     fix_hi;
   logic [WIDTH-1:0]     fix_lo;

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      a_mag     = (!op[0] && a[WIDTH-1]) ? (~a + 1'b1) : a;
      b_mag     = (!op[0] && b[WIDTH-1]) ? (~b + 1'b1) : b;

      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      trial     = rem_shift - {1'b0, operand};
      // rem < divisor keeps the difference within +/-2^WIDTH, so bit WIDTH is its sign;
      // with a zero divisor every trial must succeed to yield an all-ones quotient.
      trial_neg = trial[WIDTH] & ~zero_div;

      acc_next  = {mul_sum, acc[WIDTH-1:1]};
      if (is_div) begin
         if (trial_neg)
            acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         else
            acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end

      prod_neg  = ~acc + 1'b1;
      fix_hi    = (sign_a ^ sign_b) ? prod_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_lo    = (sign_a ^ sign_b) ? prod_neg[WIDTH-1:0]       : acc[WIDTH-1:0];
      if (is_div) begin
         fix_lo = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
         fix_hi = sign_a ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         count    <= '0;
         is_div   <= 1'b0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         zero_div <= 1'b0;
         operand  <= '0;
         acc      <= '0;
         busy     <= 1'b0;
         ready    <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
         div_zero <= 1'b0;
      end else if (ena) begin
         ready <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // Sign flags stay 0 for unsigned ops, so the fix cycle needs no op decode.
                  is_div   <= op[1];
                  sign_a   <= ~op[0] & a[WIDTH-1];
                  sign_b   <= ~op[0] & b[WIDTH-1];
                  zero_div <= op[1] && (b == '0);
                  operand  <= op[1] ? b_mag : a_mag;
                  acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                  count    <= '0;
                  busy     <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               acc   <= acc_next;
               count <= count + 1'b1;
               if (count == CW'(WIDTH - 1))
                  state <= FIX;
            end
            FIX: begin
               hi_out   <= fix_hi;
               lo_out   <= fix_lo;
               div_zero <= is_div & zero_div;
               ready    <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ena = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          busy;
   logic          ready;
   logic [W-1:0]  hi_out;
   logic [W-1:0]  lo_out;
   logic          div_zero;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .ena(ena), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .ready(ready), .hi_out(hi_out), .lo_out(lo_out), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: {hi, lo} straight from integer arithmetic and the divide-by-zero rules.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      longint sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'b00: begin p = 64'(sx * sy); return p; end
         2'b01: begin p = {32'd0, x} * {32'd0, y}; return p; end
         2'b10: begin
            if (y == 0) return {x, (x[W-1] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (y == 0) return {x, 32'hFFFF_FFFF};
            return {x % y, x / y};
         end
      endcase
   endfunction

   task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom); a = $urandom; b = $urandom;
   endtask

   // Counts enabled edges after the start edge until ready is seen (bounded).
   task automatic wait_done(output int cyc, output int busy_n);
      cyc = 0;
      busy_n = busy ? 1 : 0;
      while (!ready && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (busy) busy_n++;
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (ready !== 1'b0)    begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
      checks++; if (hi_out !== '0)     begin errors++; $display("FAIL reset_hi: got %h expected 0", hi_out); end
      checks++; if (lo_out !== '0)     begin errors++; $display("FAIL reset_lo: got %h expected 0", lo_out); end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", div_zero); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_multu_timing;
      int cyc, busy_n;
      launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(cyc, busy_n);
      checks++; if (cyc !== 33)    begin errors++; $display("FAIL multu_latency: got %0d expected 33", cyc); end
      checks++; if (busy_n !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 33", busy_n); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_ready: got %b expected 0", busy); end
      checks++;
      if ({hi_out, lo_out} !== 64'hFFFF_FFFE_0000_0001) begin
         errors++; $display("FAIL multu_max: got %h_%h expected fffffffe_00000001", hi_out, lo_out);
      end
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_width: got %b expected 0", ready); end
   endtask

   typedef struct {
      logic [1:0]   o;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } vec_t;

   task automatic test_directed;
      vec_t v[8];
      int cyc, busy_n;
      v[0] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      v[1] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
      v[2] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,         1'b0};
      v[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      v[4] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
      v[5] = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
      v[6] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'h0000_0001, 1'b1};
      v[7] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
      for (int i = 0; i < 8; i++) begin
         launch(v[i].o, v[i].x, v[i].y);
         wait_done(cyc, busy_n);
         checks++; if (cyc !== 33) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 33", i, cyc); end
         checks++;
         if (hi_out !== v[i].hi || lo_out !== v[i].lo) begin
            errors++; $display("FAIL dir%0d_result: got %h_%h expected %h_%h", i, hi_out, lo_out, v[i].hi, v[i].lo);
         end
         checks++; if (div_zero !== v[i].dz) begin errors++; $display("FAIL dir%0d_dz: got %b expected %b", i, div_zero, v[i].dz); end
      end
   endtask

   task automatic test_random;
      int cyc, busy_n;
      logic [1:0]   o;
      logic [W-1:0] x, y;
      logic [63:0]  exp_r;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom);
         x = $urandom;
         case ($urandom_range(0, 3))
            0: y = '0;
            1: y = $urandom_range(1, 15);
            2: y = 32'hFFFF_FFFF - $urandom_range(0, 7);
            default: y = $urandom;
         endcase
         exp_r = model(o, x, y);
         launch(o, x, y);
         wait_done(cyc, busy_n);
         checks++;
         if ({hi_out, lo_out} !== exp_r) begin
            errors++; $display("FAIL rand%0d op=%b a=%h b=%h: got %h_%h expected %h", i, o, x, y, hi_out, lo_out, exp_r);
         end
         checks++;
         if (div_zero !== (o[1] && y == 0)) begin
            errors++; $display("FAIL rand%0d_dz: got %b expected %b", i, div_zero, (o[1] && y == 0));
         end
      end
   endtask

   task automatic test_start_ignored;
      int cyc;
      logic [W-1:0] x, y;
      x = $urandom; y = $urandom;
      launch(2'b01, x, y);
      cyc = 0;
      while (!ready && cyc < 200) begin
         if (cyc == 5) begin
            start = 1'b1; op = 2'b10; a = $urandom; b = $urandom;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      checks++; if (cyc !== 33) begin errors++; $display("FAIL ignore_latency: got %0d expected 33", cyc); end
      checks++;
      if ({hi_out, lo_out} !== model(2'b01, x, y)) begin
         errors++; $display("FAIL ignore_result: got %h_%h expected %h", hi_out, lo_out, model(2'b01, x, y));
      end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_second_op: got busy %b expected 0", busy); end
   endtask

   task automatic test_start_without_ena;
      int seen = 0;
      @(negedge clk);
      ena = 1'b0; start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
      repeat (3) begin
         @(negedge clk);
         if (busy) seen++;
      end
      start = 1'b0; ena = 1'b1;
      @(negedge clk);
      if (busy) seen++;
      checks++; if (seen !== 0) begin errors++; $display("FAIL ena_low_start: got %0d busy cycles expected 0", seen); end
   endtask

   task automatic test_back_to_back;
      int cyc, busy_n;
      logic [W-1:0] x1, y1, x2, y2;
      x1 = $urandom; y1 = $urandom_range(1, 1000);
      x2 = $urandom; y2 = $urandom;
      launch(2'b11, x1, y1);
      wait_done(cyc, busy_n);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 33", cyc); end
      start = 1'b1; op = 2'b00; a = x2; b = y2;
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom;
      checks++; if (busy !== 1'b1 || ready !== 1'b0) begin
         errors++; $display("FAIL b2b_accept: got busy %b ready %b expected busy 1 ready 0", busy, ready);
      end
      checks++;
      if ({hi_out, lo_out} !== model(2'b11, x1, y1)) begin
         errors++; $display("FAIL b2b_hold_first: got %h_%h expected %h", hi_out, lo_out, model(2'b11, x1, y1));
      end
      wait_done(cyc, busy_n);
      checks++; if (cyc + 1 !== 34) begin errors++; $display("FAIL b2b_spacing: got %0d expected 34", cyc + 1); end
      checks++;
      if ({hi_out, lo_out} !== model(2'b00, x2, y2)) begin
         errors++; $display("FAIL b2b_second: got %h_%h expected %h", hi_out, lo_out, model(2'b00, x2, y2));
      end
   endtask

   task automatic test_reset_mid;
      int cyc, busy_n;
      int ready_seen = 0;
      launch(2'b10, 32'hF000_1234, 32'd37);
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || ready !== 1'b0) begin
         errors++; $display("FAIL midrst_ctrl: got busy %b ready %b expected 0 0", busy, ready);
      end
      checks++; if (hi_out !== '0 || lo_out !== '0 || div_zero !== 1'b0) begin
         errors++; $display("FAIL midrst_outputs: got %h_%h dz %b expected zeros", hi_out, lo_out, div_zero);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (ready) ready_seen++;
      end
      checks++; if (ready_seen !== 0) begin errors++; $display("FAIL midrst_no_ready: got %0d pulses expected 0", ready_seen); end
      launch(2'b11, 32'd9, 32'd4);
      wait_done(cyc, busy_n);
      checks++; if (cyc !== 33) begin errors++; $display("FAIL post_rst_latency: got %0d expected 33", cyc); end
      checks++; if (hi_out !== 32'd1 || lo_out !== 32'd2) begin
         errors++; $display("FAIL post_rst_divu: got %h_%h expected 00000001_00000002", hi_out, lo_out);
      end
   endtask

   task automatic test_ena_stall;
      int cyc;
      logic [W-1:0] x, y;
      logic [63:0]  exp_r;
      x = $urandom; y = $urandom;
      exp_r = model(2'b00, x, y);
      launch(2'b00, x, y);
      cyc = 0;
      while (!ready && cyc < 200) begin
         if (cyc == 10) ena = 1'b0;
         if (cyc == 15) ena = 1'b1;
         @(negedge clk);
         cyc++;
      end
      ena = 1'b1;
      checks++; if (cyc !== 38) begin errors++; $display("FAIL stall_latency: got %0d expected 38", cyc); end
      checks++; if ({hi_out, lo_out} !== exp_r) begin
         errors++; $display("FAIL stall_result: got %h_%h expected %h", hi_out, lo_out, exp_r);
      end
      ena = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_hold_ena0: got %b expected 1", ready); end
      checks++; if ({hi_out, lo_out} !== exp_r) begin
         errors++; $display("FAIL result_hold_ena0: got %h_%h expected %h", hi_out, lo_out, exp_r);
      end
      ena = 1'b1;
      @(negedge clk);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_clear_ena1: got %b expected 0", ready); end
   endtask

   initial begin
      test_reset;
      test_multu_timing;
      test_directed;
      test_random;
      test_start_ignored;
      test_start_without_ena;
      test_back_to_back;
      test_reset_mid;
      test_ena_stall;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
